// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter controller.
//   arb_state_e  : controller state (ARB_IDLE = no owner, ARB_BUSY = one owner)
//   NUM_REQ_DEF  : default number of requesters
//   MAX_HOLD_DEF : default maximum consecutive grant cycles when timeout is built in
package arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF  = 4;
  localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority find-first.
// Searches req_i & ~excl_i starting at index start_i, wrapping from N-1 to 0,
// and returns the first eligible bit as a one-hot vector.
// Ports:
//   req_i   [N-1:0]   request vector
//   start_i [IDW-1:0] index where the search begins (must be < N)
//   excl_i  [N-1:0]   bits that may not win
//   pick_o  [N-1:0]   one-hot winner, all-zero when nothing is eligible
//   found_o           a winner exists
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] start_i,
  input  logic [N-1:0]   excl_i,
  output logic [N-1:0]   pick_o,
  output logic           found_o
);

  logic [N-1:0] eligible;
  assign eligible = req_i & ~excl_i;

  always_comb begin
    int  idx;
    logic hit;
    idx    = 0;
    hit    = 1'b0;
    pick_o = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(start_i) + k;
      if (idx >= N) idx = idx - N;
      if (!hit && eligible[idx]) begin
        pick_o[idx] = 1'b1;
        hit         = 1'b1;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter controller with registered one-hot grant.
// A granted requester keeps the grant for as long as it requests; when it drops,
// the grant moves to the next round-robin winner on the same edge (no bubble).
// Optional macro ARB_TIMEOUT_EN adds preemption after MAX_HOLD consecutive grant
// cycles; without it there is no hold counter at all.
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   request      [NUM_REQ-1:0] level-sensitive requests
//   grant        [NUM_REQ-1:0] registered grant, one-hot or zero
//   grant_valid  registered OR of grant
//   grant_id     [ID_W-1:0] registered index of the granted requester, 0 if none
//   state_dbg    current controller state, for observation only
//
// Handshake: a requester holds its request bit high until it is done; it owns
// the resource in every cycle its grant bit is high, and releases it by
// dropping the request. The grant follows one edge after the sampled request.
module rr_arbiter_ctrl
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] request,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output arb_state_e         state_dbg
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               valid_q, valid_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic [NUM_REQ-1:0] excl;
  logic [NUM_REQ-1:0] pick;
  logic               found;
  logic [ID_W-1:0]    pick_id;
  logic               owner_req;
  logic               take_new;

  assign owner_req = |(request & grant_q);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout;

  assign timeout = (state_q == ARB_BUSY) && owner_req &&
                   (hold_q == HOLD_W'(MAX_HOLD - 1));
  // The pointer already sits at owner+1, so excluding the owner is all
  // that is needed to search "from owner+1, skipping the owner".
  assign excl = timeout ? grant_q : '0;
`else
  assign excl = '0;
`endif

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_pick (
    .req_i   (request),
    .start_i (ptr_q),
    .excl_i  (excl),
    .pick_o  (pick),
    .found_o (found)
  );

  always_comb begin
    pick_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    valid_d  = valid_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    take_new = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d   = hold_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (found) take_new = 1'b1;
      end
      ARB_BUSY: begin
        if (owner_req) begin
`ifdef ARB_TIMEOUT_EN
          if (timeout) begin
            // Nobody else waiting: owner keeps the grant, window restarts.
            if (found) take_new = 1'b1;
            else       hold_d   = '0;
          end else if (hold_q != HOLD_W'(MAX_HOLD - 1)) begin
            hold_d = hold_q + 1'b1;
          end
`endif
        end else if (found) begin
          take_new = 1'b1;
        end else begin
          state_d = ARB_IDLE;
          grant_d = '0;
          valid_d = 1'b0;
          id_d    = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
        id_d    = '0;
      end
    endcase

    if (take_new) begin
      state_d = ARB_BUSY;
      grant_d = pick;
      valid_d = 1'b1;
      id_d    = pick_id;
      ptr_d   = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
`ifdef ARB_TIMEOUT_EN
      hold_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`endif

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;
  assign state_dbg   = state_q;

endmodule
